// File: rtl/motor_drive_sequencer_if.sv
// Command channel between a speed/mode command source and the motor drive sequencer.
// Valid/ready handshake carrying a requested mode and a target speed.
interface motor_drive_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [9:0] cmd_speed;

  modport master (
    output cmd_valid,
    output cmd_mode,
    output cmd_speed,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    input  cmd_speed,
    output cmd_ready
  );
endinterface

// File: rtl/motor_drive_sequencer.sv
// Ramps Motor speed toward the commanded target, forces decel + dwell before any mode
// change, and adds emergency stop and a command watchdog.
module motor_drive_sequencer #(
  parameter int unsigned RAMP_DIV  = 100000,
  parameter int unsigned RAMP_STEP = 16,
  parameter int unsigned DWELL_CYC = 5000000,
  parameter int unsigned WDOG_CYC  = 50000000
) (
  input  logic                     clk,
  input  logic                     rst,
  motor_drive_sequencer_if.slave   cmd,
  input  logic                     estop,
  output logic [1:0]               mode,
  output logic [9:0]               speed,
  output logic                     busy,
  output logic                     timeout
);

  localparam int unsigned DIV_W   = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
  localparam int unsigned DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int unsigned WDOG_W  = $clog2(WDOG_CYC + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(RAMP_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [WDOG_W-1:0]  WDOG_LAST  = WDOG_W'(WDOG_CYC - 1);
  localparam logic [WDOG_W-1:0]  WDOG_MAX   = WDOG_W'(WDOG_CYC);
  localparam logic [10:0]        STEP11     = 11'(RAMP_STEP);

  typedef enum logic [2:0] {
    ST_STOPPED,
    ST_RUN,
    ST_DECEL,
    ST_DWELL,
    ST_ESTOP
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [9:0]         speed_q, speed_d;
  logic [1:0]         tgt_mode_q, tgt_mode_d;
  logic [9:0]         tgt_speed_q, tgt_speed_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [WDOG_W-1:0]  wdog_q, wdog_d;

  logic accept;
  logic tick;
  logic expire;

  // One ramp step toward tgt; the up path uses 11 bits so it cannot wrap past 1023.
  function automatic logic [9:0] ramp_toward(input logic [9:0] cur, input logic [9:0] tgt);
    logic [10:0] up_sum;
    logic [10:0] gap;
    up_sum = {1'b0, cur} + STEP11;
    gap    = {1'b0, cur} - {1'b0, tgt};
    if (cur < tgt) begin
      ramp_toward = (up_sum > {1'b0, tgt}) ? tgt : up_sum[9:0];
    end else if (gap > STEP11) begin
      ramp_toward = cur - STEP11[9:0];
    end else begin
      ramp_toward = tgt;
    end
  endfunction

  assign cmd.cmd_ready = (state_q != ST_ESTOP) && !estop;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign tick          = (div_q == DIV_LAST);
  // An accept or an estop in the expiry cycle takes precedence over the watchdog.
  assign expire        = !accept && !estop && (wdog_q == WDOG_LAST);

  always_comb begin
    // NOTE: every _d is given its hold value first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    mode_d      = mode_q;
    speed_d     = speed_q;
    tgt_mode_d  = tgt_mode_q;
    tgt_speed_d = tgt_speed_q;
    timeout_d   = timeout_q;
    dwell_d     = dwell_q;
    wdog_d      = wdog_q;
    div_d       = tick ? '0 : div_q + 1'b1;

    if (accept) begin
      tgt_mode_d  = cmd.cmd_mode;
      tgt_speed_d = cmd.cmd_speed;
      wdog_d      = '0;
      timeout_d   = 1'b0;
    end else begin
      if (wdog_q != WDOG_MAX) wdog_d = wdog_q + 1'b1;
      if (expire) begin
        timeout_d   = 1'b1;
        tgt_mode_d  = 2'b00;
        tgt_speed_d = '0;
      end
    end

    if (estop) begin
      state_d     = ST_ESTOP;
      mode_d      = 2'b00;
      speed_d     = '0;
      tgt_mode_d  = 2'b00;
      tgt_speed_d = '0;
      dwell_d     = '0;
    end else begin
      unique case (state_q)
        ST_STOPPED: begin
          if (tgt_mode_q != 2'b00 && tgt_speed_q != '0) begin
            mode_d  = tgt_mode_q;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tgt_mode_q != mode_q) begin
            state_d = ST_DECEL;
          end else if (speed_q == '0 && tgt_speed_q == '0) begin
            mode_d  = 2'b00;
            state_d = ST_STOPPED;
          end else if (tick) begin
            speed_d = ramp_toward(speed_q, tgt_speed_q);
          end
        end
        ST_DECEL: begin
          if (tgt_mode_q == mode_q && tgt_mode_q != 2'b00) begin
            state_d = ST_RUN;
          end else if (speed_q == '0) begin
            mode_d  = 2'b00;
            dwell_d = '0;
            state_d = ST_DWELL;
          end else if (tick) begin
            speed_d = ramp_toward(speed_q, '0);
          end
        end
        ST_DWELL: begin
          if (dwell_q == DWELL_LAST) state_d = ST_STOPPED;
          else                       dwell_d = dwell_q + 1'b1;
        end
        ST_ESTOP: begin
          dwell_d = '0;
          state_d = ST_DWELL;
        end
        default: state_d = ST_STOPPED;
      endcase
    end

    busy_d = (state_d == ST_DECEL) || (state_d == ST_DWELL) || (state_d == ST_ESTOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_STOPPED;
      mode_q      <= 2'b00;
      speed_q     <= '0;
      tgt_mode_q  <= 2'b00;
      tgt_speed_q <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      div_q       <= '0;
      dwell_q     <= '0;
      wdog_q      <= '0;
    end else begin
      // NOTE: state is updated with <= so every flop samples the same pre-edge values.
      state_q     <= state_d;
      mode_q      <= mode_d;
      speed_q     <= speed_d;
      tgt_mode_q  <= tgt_mode_d;
      tgt_speed_q <= tgt_speed_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      div_q       <= div_d;
      dwell_q     <= dwell_d;
      wdog_q      <= wdog_d;
    end
  end

  assign mode    = mode_q;
  assign speed   = speed_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_motor_drive_sequencer.sv
// Directed bench for motor_drive_sequencer with short ramp/dwell/watchdog parameters.
// Expected values are hand-computed for RAMP_DIV=4, RAMP_STEP=100, DWELL_CYC=10, WDOG_CYC=200.
module tb_motor_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       estop;
  logic [1:0] mode;
  logic [9:0] speed;
  logic       busy;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  motor_drive_sequencer_if cmd_if ();

  motor_drive_sequencer #(
    .RAMP_DIV (4),
    .RAMP_STEP(100),
    .DWELL_CYC(10),
    .WDOG_CYC (200)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd_if),
    .estop  (estop),
    .mode   (mode),
    .speed  (speed),
    .busy   (busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] m, input logic [9:0] s);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_speed = s;
    step();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Steps until speed differs from prev, or the budget runs out (then now == prev).
  task automatic wait_speed_change(input logic [9:0] prev, input int budget, output logic [9:0] now);
    now = speed;
    for (int i = 0; i < budget; i++) begin
      step();
      if (speed !== prev) begin
        now = speed;
        break;
      end
    end
  endtask

  initial begin
    logic [9:0] prev;
    logic [9:0] now;
    int         cnt;
    int         k;
    bit         seen;

    rst              = 1'b0;
    estop            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_speed = '0;
    step();
    step();
    rst = 1'b1;
    check("rst_mode", mode, 0);
    check("rst_speed", speed, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ready", cmd_if.cmd_ready, 1);

    // 1: ramp up to a target that is not a multiple of the step.
    send_cmd(2'b01, 10'd750);
    step();
    check("t1_mode", mode, 1);
    prev = 0;
    for (int v = 100; v <= 700; v += 100) begin
      wait_speed_change(prev, 8, now);
      check("t1_ramp", now, v);
      check("t1_busy", busy, 0);
      prev = now;
    end
    wait_speed_change(prev, 8, now);
    check("t1_clamp", now, 750);
    for (int i = 0; i < 8; i++) step();
    check("t1_hold", speed, 750);
    check("t1_hold_busy", busy, 0);

    // 2: mode change forces decel, dwell, then ramp in the new mode.
    send_cmd(2'b01, 10'd700);
    wait_speed_change(10'd750, 10, now);
    check("t2_at700", now, 700);
    send_cmd(2'b10, 10'd500);
    step();
    check("t2_busy", busy, 1);
    check("t2_mode_kept", mode, 1);
    prev = 700;
    for (int v = 600; v >= 0; v -= 100) begin
      wait_speed_change(prev, 8, now);
      check("t2_decel", now, v);
      check("t2_decel_mode", mode, 1);
      prev = now;
    end
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mode == 2'b10) break;
      if (mode == 2'b00 && busy) cnt++;
    end
    check("t2_dwell_len", cnt, 10);
    check("t2_new_mode", mode, 2);
    check("t2_new_speed0", speed, 0);
    prev = 0;
    for (int v = 100; v <= 500; v += 100) begin
      wait_speed_change(prev, 8, now);
      check("t2_ramp", now, v);
      prev = now;
    end
    check("t2_busy_end", busy, 0);

    // 3: same-mode speed changes ramp without a mode-00 gap; speed 0 ends STOPPED.
    send_cmd(2'b01, 10'd700);
    for (int i = 0; i < 150; i++) begin
      step();
      if (speed == 10'd700 && mode == 2'b01) break;
    end
    check("t3_at700", speed, 700);
    send_cmd(2'b01, 10'd300);
    prev = 700;
    for (int v = 600; v >= 300; v -= 100) begin
      wait_speed_change(prev, 8, now);
      check("t3_down", now, v);
      check("t3_down_mode", mode, 1);
      check("t3_down_busy", busy, 0);
      prev = now;
    end
    send_cmd(2'b01, 10'd0);
    for (int v = 200; v >= 0; v -= 100) begin
      wait_speed_change(prev, 8, now);
      check("t3_to0", now, v);
      check("t3_to0_mode", mode, 1);
      prev = now;
    end
    step();
    check("t3_stopped_mode", mode, 0);
    check("t3_no_dwell", busy, 0);

    // 4: estop during ramp-up, command dropped, dwell after release, stays stopped.
    send_cmd(2'b01, 10'd700);
    prev = 0;
    for (int v = 100; v <= 400; v += 100) begin
      wait_speed_change(prev, 8, now);
      check("t4_ramp", now, v);
      prev = now;
    end
    estop = 1'b1;
    #1;
    check("t4_ready_lo", cmd_if.cmd_ready, 0);
    step();
    check("t4_speed0", speed, 0);
    check("t4_mode0", mode, 0);
    check("t4_busy", busy, 1);
    send_cmd(2'b10, 10'd500);
    check("t4_drop_mode", mode, 0);
    estop = 1'b0;
    #1;
    check("t4_ready_estop_state", cmd_if.cmd_ready, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) cnt++;
      else break;
    end
    check("t4_dwell_len", cnt, 10);
    for (int i = 0; i < 20; i++) step();
    check("t4_stay_mode", mode, 0);
    check("t4_stay_speed", speed, 0);
    check("t4_ready_hi", cmd_if.cmd_ready, 1);
    check("t4_timeout", timeout, 0);

    // 5: watchdog expiry 200 cycles after the last accept, then decel/dwell/stop.
    send_cmd(2'b01, 10'd400);
    k    = 0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      k++;
      if (speed == 10'd400) seen = 1'b1;
      if (timeout) break;
    end
    check("t5_reached400", seen, 1);
    check("t5_expiry_cycle", k, 200);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy) seen = 1'b1;
      if (mode == 2'b00 && speed == '0 && !busy) break;
    end
    check("t5_went_busy", seen, 1);
    check("t5_stop_mode", mode, 0);
    check("t5_stop_speed", speed, 0);
    check("t5_timeout_sticky", timeout, 1);
    send_cmd(2'b01, 10'd200);
    check("t5_timeout_clr", timeout, 0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (speed == 10'd200) break;
    end
    check("t5_restart_speed", speed, 200);
    check("t5_restart_mode", mode, 1);

    // 6: asynchronous reset mid-RUN.
    step();
    step();
    #3;
    rst = 1'b0;
    #1;
    check("t6_mode", mode, 0);
    check("t6_speed", speed, 0);
    check("t6_timeout", timeout, 0);
    check("t6_busy", busy, 0);
    step();
    step();
    #4;
    rst = 1'b1;
    step();
    check("t6_ready", cmd_if.cmd_ready, 1);
    for (int i = 0; i < 10; i++) step();
    check("t6_stay_mode", mode, 0);
    check("t6_stay_speed", speed, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motor_drive_sequencer.md
Name: motor_drive_sequencer

Overview:
- Sits between the command sources (switch/test logic, line-tracking FSM) and the Motor PWM block, and drives Motor's mode and speed inputs.
- Accepts mode/speed commands over a valid/ready handshake and ramps speed toward the target.
- Forces a decelerate-to-zero plus stop-dwell before any mode change, so the H-bridge is never reversed under load.
- Provides an emergency stop and a command watchdog.

Parameters:
RAMP_DIV, 100000, clk cycles per ramp tick (1 ms at 100 MHz)
RAMP_STEP, 16, speed change per ramp tick
DWELL_CYC, 5000000, cycles held in mode 00 after decel before a new mode (50 ms)
WDOG_CYC, 50000000, cycles without an accepted command before forced stop (0.5 s)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; comb: (state!=ESTOP) && !estop
cmd_mode  in  2  requested mode; 00 = stop, others = drive modes passed to Motor
cmd_speed  in  10  requested speed 0..1023
estop  in  1  emergency stop, level sensitive
mode  out  2  to Motor.mode, registered
speed  out  10  to Motor.speed, registered
busy  out  1  registered; 1 in DECEL, DWELL, ESTOP
timeout  out  1  sticky watchdog flag, registered

Behaviour:
- Reset (rst=0, async): state=STOPPED, mode=00, speed=0, tgt_mode=00, tgt_speed=0, busy=0, timeout=0, all counters 0. cmd_ready=1 after reset when estop=0.
- Accept: cmd_valid && cmd_ready latches tgt_mode/tgt_speed at the clock edge. Latest command wins; no queueing. The FSM acts on the target from the next cycle.
- Ramp tick: free-running divider 0..RAMP_DIV-1; tick when it equals RAMP_DIV-1. Speed changes only on tick cycles.
- Step arithmetic:
  - up: speed = min(speed+RAMP_STEP, target), computed in 11 bits.
  - down: speed = max(speed-RAMP_STEP, target), no underflow.
  - Never overshoots the target.
- STOPPED (mode 00, speed 0):
  - if tgt_mode!=00 && tgt_speed!=0: mode<=tgt_mode, speed stays 0, go RUN.
  - otherwise stay.
- RUN, tgt_mode==mode: ramp toward tgt_speed on ticks. If speed reaches 0 with tgt_speed==0, then mode<=00 and go STOPPED (no dwell).
- RUN, tgt_mode!=mode (including tgt 00): go DECEL next cycle.
- DECEL:
  - Ramp toward 0 on ticks; mode unchanged.
  - If a new command makes tgt_mode==mode and tgt_mode!=00, return to RUN.
  - When speed==0: mode<=00, clear dwell counter, go DWELL.
- DWELL: mode 00, speed 0 for exactly DWELL_CYC cycles, then go STOPPED. Commands are accepted but do not shorten the dwell.
- ESTOP:
  - estop=1 in any state: next edge sets speed=0, mode=00, tgt=00/0, state=ESTOP.
  - cmd_ready=0 while estop=1 or state==ESTOP.
  - Leave on the first cycle estop=0 into DWELL (counter cleared), then STOPPED. Restart requires a new command.
- Watchdog:
  - Counter clears on each accept and saturates at WDOG_CYC.
  - On reaching WDOG_CYC: timeout<=1, tgt<=00/0, so a running motor goes DECEL, DWELL, STOPPED.
  - timeout clears on the next accepted command.
- Simultaneous events:
  - estop beats a same-cycle command; the command is dropped.
  - An accept in the watchdog expiry cycle wins; timeout is not set.
  - estop beats watchdog expiry.
- Mid-operation reset forces reset values immediately, with no decel.

Test Plan:
(bench params: RAMP_DIV=4, RAMP_STEP=100, DWELL_CYC=10, WDOG_CYC=200)
1. Reset, then cmd (01,750) -> mode=01 within 2 cycles; speed 100,200..700, then 750 (clamped) on successive ticks; holds 750; busy=0.
2. Running 01@700, cmd (10,500) -> busy=1; speed falls 100/tick with mode=01 to 0; mode=00 for exactly 10 cycles; STOPPED; mode=10; ramps to 500; busy=0.
3. Running 01@700, cmd (01,300) -> speed ramps 600,500,400,300 with no mode-00 gap. Then cmd (01,0) -> ramps to 0, ends STOPPED with mode 00.
4. estop pulse during ramp-up at speed 400 -> next edge speed=0, mode=00, cmd_ready=0; a cmd during estop is dropped. After release: 10-cycle dwell, STOPPED, stays stopped.
5. Running 01@400, no cmds for 200 cycles -> timeout=1, decel to 0, dwell, STOPPED. Next cmd (01,200) clears timeout and restarts.
6. rst low mid-RUN, asynchronous to clk -> mode=00, speed=0, timeout=0 without waiting for a clock edge. After release: STOPPED, cmd_ready=1.
